// File: rtl/aes_axis_rx_pkg.sv
// Shared definitions for the AES stream ingress stage.
//   WORD_S / BLK_S / BYTE_S : stream word, cipher block and byte widths
//   ENCRYPT / SET_KEY       : command word encodings carried in word 0
//   rx_state_e              : ingress FSM states
package aes_axis_rx_pkg;

    localparam int WORD_S = 32;
    localparam int BLK_S  = 128;
    localparam int BYTE_S = 8;

    localparam logic [WORD_S-1:0] ENCRYPT = 32'h0000_0001;
    localparam logic [WORD_S-1:0] SET_KEY = 32'h0000_0002;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA      = 2'd1,
        ST_COMMIT    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } rx_state_e;

endpackage

// File: rtl/aes_blk_packer.sv
// Packs 32-bit stream words four at a time into one 128-bit block.
// Lane 0 occupies bits [0:31] (most significant word). A block is
// reported combinationally on the word that completes it (fourth lane
// or last word of the packet); lanes not written stay zero.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart lane counter (start of a new packet)
//   word_valid  : a payload word is being accepted this cycle
//   word_data   : payload word
//   word_last   : accepted word is the last of the packet
//   blk_valid   : this cycle's word completes a block
//   blk_data    : assembled block including this cycle's word
module aes_blk_packer
    import aes_axis_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              word_valid,
    input  logic [WORD_S-1:0] word_data,
    input  logic              word_last,
    output logic              blk_valid,
    output logic [0:BLK_S-1]  blk_data
);

    logic [1:0]         word_idx_r;
    logic [0:BLK_S-1]   asm_r;
    logic [0:BLK_S-1]   asm_s;

    // Merge the incoming word into its lane; lane 0 starts from an all-zero block
    always_comb begin
        asm_s = asm_r;
        if (word_idx_r == 2'd0) begin
            asm_s = {BLK_S{1'b0}};
        end else begin
            asm_s = asm_r;
        end
        asm_s[{word_idx_r, 5'd0} +: WORD_S] = word_data;
        blk_valid = word_valid && ((word_idx_r == 2'd3) || word_last);
        blk_data  = asm_s;
    end

    // Lane counter and partial-block register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_idx_r <= 2'd0;
            asm_r      <= {BLK_S{1'b0}};
        end else if (word_valid) begin
            asm_r      <= asm_s;
            word_idx_r <= word_last ? 2'd0 : (word_idx_r + 2'd1);
        end
    end

endmodule

// File: rtl/aes_axis_rx.sv
// AXI-Stream ingress for the AES datapath. Word 0 of each packet is the
// command; remaining words are packed into 128-bit input FIFO entries.
// At packet end the command and block count are published, en_o pulses
// once, and the stream is stalled until done_i.
//   clk, reset      : clock, synchronous active-high reset
//   s_axis_*        : 32-bit stream slave (tdata/tvalid/tready/tlast)
//   aes_cmd         : latched command word
//   in_fifo_w_e     : FIFO write strobe
//   in_fifo_addr    : FIFO write address
//   in_fifo_data    : FIFO write data
//   in_fifo_blk_cnt : blocks written for the current packet
//   en_o            : one-cycle start pulse to the controller
//   done_i          : controller completion, honoured only while waiting
//   overflow_o      : sticky, packet held more than 2**W-1 blocks
module aes_axis_rx
    import aes_axis_rx_pkg::*;
#(
    parameter int IN_FIFO_ADDR_WIDTH = 9,
    parameter int IN_FIFO_DATA_WIDTH = BLK_S
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WORD_S-1:0]             s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [0:WORD_S-1]             aes_cmd,
    output logic                          in_fifo_w_e,
    output logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_addr,
    output logic [0:IN_FIFO_DATA_WIDTH-1] in_fifo_data,
    output logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_blk_cnt,
    output logic                          en_o,
    input  logic                          done_i,
    output logic                          overflow_o
);

    localparam int AW = IN_FIFO_ADDR_WIDTH;
    localparam logic [AW-1:0] BLK_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    rx_state_e          state_r;
    logic               xfer_s;
    logic               blk_valid_s;
    logic [0:BLK_S-1]   blk_data_s;

    // The stream is open only while collecting a packet
    assign s_axis_tready = (state_r == ST_IDLE) || (state_r == ST_DATA);
    assign xfer_s        = s_axis_tvalid && s_axis_tready;

    aes_blk_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (xfer_s && (state_r == ST_IDLE)),
        .word_valid (xfer_s && (state_r == ST_DATA)),
        .word_data  (s_axis_tdata),
        .word_last  (s_axis_tlast),
        .blk_valid  (blk_valid_s),
        .blk_data   (blk_data_s)
    );

    // Packet FSM with registered FIFO-write, start pulse and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            aes_cmd         <= {WORD_S{1'b0}};
            in_fifo_w_e     <= 1'b0;
            in_fifo_addr    <= {AW{1'b0}};
            in_fifo_data    <= {IN_FIFO_DATA_WIDTH{1'b0}};
            in_fifo_blk_cnt <= {AW{1'b0}};
            en_o            <= 1'b0;
            overflow_o      <= 1'b0;
        end else begin
            in_fifo_w_e <= 1'b0;
            en_o        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        aes_cmd         <= s_axis_tdata;
                        in_fifo_blk_cnt <= {AW{1'b0}};
                        overflow_o      <= 1'b0;
                        state_r         <= s_axis_tlast ? ST_COMMIT : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (blk_valid_s) begin
                        // Once the FIFO is full the remaining blocks are dropped
                        if (in_fifo_blk_cnt == BLK_MAX) begin
                            overflow_o <= 1'b1;
                        end else begin
                            in_fifo_w_e     <= 1'b1;
                            in_fifo_addr    <= in_fifo_blk_cnt;
                            in_fifo_data    <= blk_data_s;
                            in_fifo_blk_cnt <= in_fifo_blk_cnt + CNT_ONE;
                        end
                    end
                    if (xfer_s && s_axis_tlast) begin
                        state_r <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // One spare cycle so the final FIFO write lands before the start pulse
                    en_o    <= 1'b1;
                    state_r <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
